// File: rtl/lti_pkg.sv
// Shared constants, FSM encoding and helpers for the LTI MAC sequencer.
// Optional saturation is selected with the LTI_SATURATE_EN macro.
package lti_pkg;

    localparam int NX    = 4;
    localparam int NCOL  = NX + 1;
    localparam int NROW  = NX + 1;
    localparam int IW    = 16;
    localparam int OW    = 16;
    localparam int CW    = 16;
    localparam int SW    = 18;
    localparam int RW    = SW + CW - 1;
    localparam int AW    = RW + $clog2(NCOL);
    localparam int CF    = 15;
    localparam int DEL   = 10;
    localparam int NCELL = NROW * NCOL;
    localparam int CAW   = $clog2(NCELL);
    localparam int RRW   = $clog2(NROW);
    localparam int CCW   = $clog2(NCOL);
    localparam int XIW   = $clog2(NX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_DRAIN,
        S_WB,
        S_DONE
    } state_t;

    function automatic int lat_f(input int nrow, input int ncol);
        return 2 + nrow * (ncol + 2);
    endfunction

    localparam int LAT = lat_f(NROW, NCOL);

    // Column c < NX multiplies a state, the last column multiplies u.
    function automatic logic signed [SW-1:0] sel_opnd(
        input logic [NX-1:0][SW-1:0] xq,
        input logic signed [SW-1:0]  u,
        input logic [CCW-1:0]        c
    );
        return (int'(c) < NX) ? signed'(xq[c[XIW-1:0]]) : u;
    endfunction

endpackage

// File: rtl/lti_coef_bank.sv
// Coefficient register file for [A B; C D], row-major, with write guard.
// Writes are rejected while busy or when the address is out of range.
module lti_coef_bank
    import lti_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  busy,
    input  logic                  we,
    input  logic [CAW-1:0]        addr,
    input  logic signed [CW-1:0]  data,
    input  logic [RRW-1:0]        rd_row,
    input  logic [CCW-1:0]        rd_col,
    output logic signed [CW-1:0]  rd_data,
    output logic                  wr_err
);

    logic signed [CW-1:0] mem [NCELL];
    logic                 ok;
    logic [CAW-1:0]       rd_addr;

    assign ok      = !busy && (int'(addr) < NCELL);
    assign rd_addr = CAW'(int'(rd_row) * NCOL + int'(rd_col));
    assign rd_data = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCELL; i++) mem[i] <= '0;
            wr_err <= 1'b0;
        end else if (we) begin
            if (ok) mem[addr] <= data;
            else    wr_err    <= 1'b1;
        end
    end

endmodule

// File: rtl/lti_mac_sequencer.sv
// Time-multiplexed state-space controller with one shared multiplier.
// Define LTI_SATURATE_EN to saturate the state update and output.
module lti_mac_sequencer
    import lti_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_in,
    input  logic signed [IW-1:0]  sig_in,
    output logic signed [OW-1:0]  sig_out,
    output logic                  ce_out,
    output logic                  busy,
    output logic                  overrun,
    input  logic                  coef_we,
    input  logic [CAW-1:0]        coef_addr,
    input  logic signed [CW-1:0]  coef_data,
    output logic                  wr_err
);

    state_t state, state_n;

    logic [RRW-1:0]        r;
    logic [CCW-1:0]        c;
    logic signed [SW-1:0]  u_q;
    logic [NX-1:0][SW-1:0] x_q;
    logic signed [RW-1:0]  x_long [NX];
    logic signed [RW-1:0]  prod;
    logic                  prod_vld;
    logic signed [AW-1:0]  acc;
    logic signed [CW-1:0]  coef;
    logic signed [RW-1:0]  coef_x, opnd_x;
    logic signed [RW-1:0]  x_upd;
    logic signed [OW-1:0]  y_q;
    logic                  last_col, last_row;
    logic [XIW-1:0]        rx;

    assign busy     = (state != S_IDLE);
    assign last_col = (int'(c) == NCOL - 1);
    assign last_row = (int'(r) == NROW - 1);
    assign rx       = r[XIW-1:0];
    assign coef_x   = RW'(coef);
    assign opnd_x   = RW'(sel_opnd(x_q, u_q, c));

    lti_coef_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy),
        .we      (coef_we),
        .addr    (coef_addr),
        .data    (coef_data),
        .rd_row  (r),
        .rd_col  (c),
        .rd_data (coef),
        .wr_err  (wr_err)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (ce_in) state_n = S_LOAD;
            S_LOAD:  state_n = S_MAC;
            S_MAC:   if (last_col) state_n = S_DRAIN;
            S_DRAIN: state_n = S_WB;
            S_WB:    state_n = last_row ? S_DONE : S_MAC;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

`ifdef LTI_SATURATE_EN
    localparam logic signed [AW:0] XMAX =
        {{(AW-RW+2){1'b0}}, {(RW-1){1'b1}}};
    localparam logic signed [AW:0] XMIN =
        {{(AW-RW+2){1'b1}}, {(RW-1){1'b0}}};
    localparam logic signed [AW-1:0] YMAX =
        {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] YMIN =
        {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic signed [AW:0]   xs;
    logic signed [AW-1:0] ys;

    always_comb begin
        xs = (AW+1)'(x_long[rx]) + (AW+1)'(acc >>> DEL);
        ys = acc >>> CF;
        if (xs > XMAX)      x_upd = XMAX[RW-1:0];
        else if (xs < XMIN) x_upd = XMIN[RW-1:0];
        else                x_upd = xs[RW-1:0];
        if (ys > YMAX)      y_q = YMAX[OW-1:0];
        else if (ys < YMIN) y_q = YMIN[OW-1:0];
        else                y_q = ys[OW-1:0];
    end
`else
    always_comb begin
        x_upd = x_long[rx] + RW'(acc >>> DEL);
        y_q   = acc[OW+CF-1:CF];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r        <= '0;
            c        <= '0;
            u_q      <= '0;
            x_q      <= '0;
            prod     <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
            sig_out  <= '0;
            ce_out   <= 1'b0;
            overrun  <= 1'b0;
            for (int i = 0; i < NX; i++) x_long[i] <= '0;
        end else begin
            ce_out <= 1'b0;
            if (ce_in && busy) overrun <= 1'b1;
            case (state)
                S_LOAD: begin
                    u_q      <= SW'(sig_in);
                    r        <= '0;
                    c        <= '0;
                    acc      <= '0;
                    prod_vld <= 1'b0;
                    // Every row reads this snapshot, so the update is simultaneous.
                    for (int i = 0; i < NX; i++)
                        x_q[i] <= x_long[i][SW+CF-1:CF];
                end
                S_MAC: begin
                    prod     <= coef_x * opnd_x;
                    prod_vld <= 1'b1;
                    if (prod_vld) acc <= acc + AW'(prod);
                    if (!last_col) c <= c + CCW'(1);
                end
                S_DRAIN: begin
                    acc      <= acc + AW'(prod);
                    prod_vld <= 1'b0;
                end
                S_WB: begin
                    if (int'(r) < NX) x_long[rx] <= x_upd;
                    else              sig_out    <= y_q;
                    acc <= '0;
                    c   <= '0;
                    if (last_row) ce_out <= 1'b1;
                    else          r      <= r + RRW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lti_mac_sequencer.sv
// Directed bench for lti_mac_sequencer with a sample-level reference model.
// Follows LTI_SATURATE_EN the same way the design does.
module tb_lti_mac_sequencer;
    import lti_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 ce_in = 1'b0;
    logic signed [IW-1:0] sig_in = '0;
    logic signed [OW-1:0] sig_out;
    logic                 ce_out;
    logic                 busy;
    logic                 overrun;
    logic                 coef_we = 1'b0;
    logic [CAW-1:0]       coef_addr = '0;
    logic signed [CW-1:0] coef_data = '0;
    logic                 wr_err;

    always #5 clk = ~clk;

    lti_mac_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .ce_in     (ce_in),
        .sig_in    (sig_in),
        .sig_out   (sig_out),
        .ce_out    (ce_out),
        .busy      (busy),
        .overrun   (overrun),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .wr_err    (wr_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input longint act,
                         input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d @%0t",
                      name, act, exp, $time);
    endtask

    // Reference model: whole sample computed at acceptance, outputs timed
    // by a cycle counter since acceptance.
    int     m_cnt = 0;
    longint m_x [NX];
    int     m_coef [NCELL];
    bit     m_over = 0, m_werr = 0, m_busy;
    longint m_y = 0, m_sig = 0;

    function automatic longint wrapn(input longint v, input int n);
        return (v <<< (64 - n)) >>> (64 - n);
    endfunction

    function automatic longint fitn(input longint v, input int n);
`ifdef LTI_SATURATE_EN
        longint hi = (longint'(1) <<< (n - 1)) - 1;
        longint lo = -(longint'(1) <<< (n - 1));
        return (v > hi) ? hi : (v < lo) ? lo : v;
`else
        return wrapn(v, n);
`endif
    endfunction

    task automatic run_sample(input longint u);
        longint xq [NX];
        longint nx [NX];
        longint acc, op;
        for (int i = 0; i < NX; i++) xq[i] = m_x[i] >>> CF;
        for (int row = 0; row < NROW; row++) begin
            acc = 0;
            for (int col = 0; col < NCOL; col++) begin
                op = (col < NX) ? xq[col] : u;
                acc += longint'(m_coef[row*NCOL+col]) * op;
            end
            if (row < NX) nx[row] = fitn(m_x[row] + (acc >>> DEL), RW);
            else          m_y     = fitn(acc >>> CF, OW);
        end
        for (int i = 0; i < NX; i++) m_x[i] = nx[i];
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_over = 0; m_werr = 0; m_sig = 0;
            for (int i = 0; i < NX; i++) m_x[i] = 0;
            for (int i = 0; i < NCELL; i++) m_coef[i] = 0;
        end else begin
            m_busy = (m_cnt != 0);
            if (coef_we) begin
                if (m_busy || int'(coef_addr) >= NCELL) m_werr = 1;
                else m_coef[coef_addr] = int'(coef_data);
            end
            if (ce_in && m_busy) m_over = 1;
            if (m_busy) m_cnt = (m_cnt == LAT) ? 0 : m_cnt + 1;
            else if (ce_in) begin
                m_cnt = 1;
                run_sample(longint'(sig_in));
            end
            if (m_cnt == LAT) m_sig = m_y;
        end
    end

    always @(posedge clk) begin
        #1;
        check("busy",    busy,    longint'(m_cnt != 0));
        check("ce_out",  ce_out,  longint'(m_cnt == LAT));
        check("sig_out", sig_out, m_sig);
        check("overrun", overrun, longint'(m_over));
        check("wr_err",  wr_err,  longint'(m_werr));
    end

    task automatic pulse_ce(input logic signed [IW-1:0] v);
        @(negedge clk);
        ce_in  = 1'b1;
        sig_in = v;
        @(negedge clk);
        ce_in  = 1'b0;
    endtask

    task automatic write_coef(input int a, input logic signed [CW-1:0] d);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = CAW'(a);
        coef_data = d;
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    // Called on the negedge of cycle 'start' after acceptance.
    task automatic wait_ce(input int start, output int lat);
        lat = start;
        while (!ce_out && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        if (!ce_out) check("ce_out_timeout", 0, 1);
    endtask

    int lat;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_sig_out", sig_out, 0);

        // 1: zero coefficients
        pulse_ce(16'sd1000);
        wait_ce(1, lat);
        check("t1_latency", lat, 37);
        check("t1_sig_out", sig_out, 0);
        repeat (3) @(negedge clk);

        // 2: D = 0.5 written in the same cycle as the strobe
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 5'd24; coef_data = 16'sd16384;
        ce_in = 1'b1; sig_in = 16'sd1000;
        @(negedge clk);
        coef_we = 1'b0; ce_in = 1'b0;
        wait_ce(1, lat);
        check("t2_latency", lat, 37);
        check("t2_pos", sig_out, 500);
        repeat (3) @(negedge clk);
        pulse_ce(-16'sd1000);
        wait_ce(1, lat);
        check("t2_neg", sig_out, -500);
        repeat (3) @(negedge clk);

        // 3: B row 0 integrates u into x_long[0]
        write_coef(4, 16'sd1024);
        pulse_ce(-16'sd4000);
        wait_ce(1, lat);
        check("t3_y", sig_out, -2000);
        repeat (2) @(negedge clk);
        check("t3_x_long0", dut.x_long[0], -4000);

        // 4: second strobe while busy
        repeat (2) @(negedge clk);
        pulse_ce(16'sd0);
        repeat (8) @(negedge clk);
        pulse_ce(16'sd7);
        wait_ce(11, lat);
        check("t4_latency", lat, 37);
        check("t4_overrun", overrun, 1);
        check("t4_y", sig_out, 0);
        repeat (15) @(negedge clk);
        check("t4_overrun_sticky", overrun, 1);

        // 5: rejected writes (busy, out of range)
        pulse_ce(16'sd2000);
        @(negedge clk);
        check("t5_xq0_floor", longint'($signed(dut.x_q[0])), -1);
        repeat (2) @(negedge clk);
        write_coef(24, 16'sd0);
        check("t5_wr_err_busy", wr_err, 1);
        wait_ce(6, lat);
        check("t5_y_old_coef", sig_out, 1000);
        repeat (3) @(negedge clk);
        write_coef(25, 16'sd99);
        pulse_ce(16'sd2000);
        wait_ce(1, lat);
        check("t5_y_again", sig_out, 1000);
        check("t5_wr_err", wr_err, 1);
        repeat (3) @(negedge clk);

        // 6: reset mid-sample, then output quantization corner
        pulse_ce(16'sd1234);
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_overrun", overrun, 0);
        check("t6_sig_out", sig_out, 0);
        check("t6_x_long0", dut.x_long[0], 0);
        repeat (40) @(negedge clk);
        check("t6_no_ce", ce_out, 0);
        write_coef(24, -16'sd32768);
        pulse_ce(-16'sd32768);
        wait_ce(1, lat);
`ifdef LTI_SATURATE_EN
        check("t6_corner", sig_out, 32767);
`else
        check("t6_corner", sig_out, -32768);
`endif
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lti_mac_sequencer.md
Name: lti_mac_sequencer

Overview:
Time-multiplexed state-space controller: evaluates x[k+1] = x + (A·x + B·u)>>>DEL and y = C·x + D·u using one shared multiplier and accumulator instead of one multiplier per coefficient.
- Sequences rows/columns of the combined matrix [A B; C D] from a writable coefficient bank.
- Sits between the ADC sample strobe and the DAC, where a small FPGA cannot afford 25 parallel multipliers.

Parameters:
- NX, 4, number of states
- NCOL, NX+1, columns of [A B; C D] (single input u)
- NROW, NX+1, rows of [A B; C D] (single output y)
- IW, 16, input width
- OW, 16, output width
- CW, 16, signed coefficient width
- SW, 18, quantized state/operand width
- RW, SW+CW-1, product and x_long width
- AW, RW+$clog2(NCOL), accumulator width
- CF, 15, coefficient fraction bits
- DEL, 10, delta-operator shift
- CAW, $clog2(NROW*NCOL), coefficient address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ce_in  in  1  sample strobe
- sig_in  in  IW  signed input u
- sig_out  out  OW  signed output y, held between updates
- ce_out  out  1  one-cycle pulse when sig_out is updated
- busy  out  1  high from LOAD through DONE
- overrun  out  1  sticky: ce_in arrived while busy
- coef_we  in  1  coefficient write strobe
- coef_addr  in  CAW  row-major index r*NCOL+c into [A B; C D]
- coef_data  in  CW  signed coefficient
- wr_err  out  1  sticky: write rejected (busy or address out of range)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset clears: state=IDLE; sig_out, ce_out, busy, overrun, wr_err; all x_long, acc and every coefficient. Reset mid-computation aborts it: no ce_out, and busy=0 on the next cycle.
- FSM transitions:
  - IDLE: ce_in=1 → LOAD.
  - LOAD (1 cycle): latch u = sign-extend(sig_in) to SW; snapshot x_q[i] = x_long[i][SW+CF-1:CF]; r=c=0; clear acc.
  - MAC (NCOL cycles): each cycle prod <= coef[r][c] * opnd, where opnd = x_q[c] if c<NX, else u. The product is registered (1-cycle latency) and acc += prod one cycle later.
  - DRAIN (1 cycle): last product is accumulated.
  - WB (1 cycle): if r<NX, x_long[r] <= x_long[r] + (acc>>>DEL) truncated to RW bits; else y_reg <= acc[OW+CF-1:CF]. Then acc=0 and c=0. If r=NROW-1 → DONE, else r++ and → MAC.
  - DONE (1 cycle): sig_out <= y_reg; ce_out=1; → IDLE.
- All rows use the snapshot x_q, so the state update is simultaneous even though x_long[r] is written row by row.
- Latency: ce_out is high exactly LAT = 2 + NROW*(NCOL+2) cycles after the ce_in edge is accepted; default 37. Minimum sample spacing is LAT+1.
- Overrun: ce_in in any state except IDLE (including DONE) is ignored and sets overrun.
- Coefficient writes:
  - Accepted only while busy=0 and coef_addr < NROW*NCOL; visible to the next sample.
  - Otherwise ignored and wr_err is set.
  - A write and ce_in in the same IDLE cycle: the write is accepted and applies to that sample.
- Arithmetic: all products and sums are signed; the accumulator has $clog2(NCOL) guard bits, so no overflow inside acc.

Optional Feature:
- Macro: LTI_SATURATE_EN.
- Defined: the x_long update saturates to the signed RW range, and the output quantization saturates acc to the signed OW range before slicing.
- Undefined: both truncate and wrap (two's complement).

Decomposition:
- Package lti_pkg: FSM state encoding, a localparam function computing LAT from NROW/NCOL, and the operand-select helper.
- Sub-module lti_coef_bank: NROW*NCOL×CW register file with synchronous write, reset-to-zero, combinational read at {r,c}, and address range check driving the reject flag.

Test Plan:
1. Reset, all coefficients 0, sig_in=1000, ce_in → ce_out exactly 37 cycles later; sig_out=0; busy high for cycles 1..37.
2. Write D (addr 24)=16384, sig_in=1000, ce_in → sig_out=500 at +37; a second sample with sig_in=-1000 → sig_out=-500.
3. Write B row0 (addr 4)=1024, sig_in=-4000, ce_in → x_long[0]=-4000 after the first sample. The next sample's snapshot x_q[0]=-1 (floor).
4. ce_in at T and again at T+10 → second strobe ignored; overrun=1; a single ce_out at T+37; overrun stays set until rst.
5. coef_we at T+5 (busy), then coef_we with addr 25 while idle → both rejected, wr_err=1; the next sample uses the old coefficients.
6. rst at T+20 mid-sample → no ce_out; busy=0 at T+21; x_long and sig_out=0. Then D=-32768 with sig_in=-32768 → sig_out=32767 with LTI_SATURATE_EN, -32768 without.
